// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold and forced revocation after MAX_HOLD cycles.
// One idle cycle always separates consecutive grants; timeout pulses in that gap.
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  MaxCnt  = CW'(MAX_HOLD);
  localparam logic [CW-1:0]  CntOne  = CW'(1);
  localparam logic [IDW-1:0] LastId  = IDW'(N - 1);
  localparam logic [N-1:0]   OneHot0 = N'(1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         state_q;
  logic [N-1:0]   gnt_q;
  logic [IDW-1:0] gnt_id_q;
  logic [IDW-1:0] ptr_q;
  logic [CW-1:0]  cnt_q;
  logic           timeout_q;

  logic           pick_valid;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] ptr_next;
  logic           owner_req;
  int             idx;

  // Scan from lowest to highest priority so the last hit wins: ptr itself is highest.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  assign owner_req = req[gnt_id_q];
  assign ptr_next  = (gnt_id_q == LastId) ? '0 : gnt_id_q + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q  <= StGrant;
            gnt_q    <= OneHot0 << pick_id;
            gnt_id_q <= pick_id;
            cnt_q    <= CntOne;
          end
        end
        StGrant: begin
          // A simultaneous drop at the limit counts as a normal release.
          if (!owner_req || cnt_q == MaxCnt) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            ptr_q     <= ptr_next;
            cnt_q     <= '0;
            timeout_q <= owner_req;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: reactive clients drive directed and random traffic,
// a rotation-distance reference model is compared every cycle.
module tb_rr_hold_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW      = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: owner (-1 when idle), visible-cycle count, rotation pointer.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;
  int m_id    = 0;
  bit m_tmo   = 0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      if (r[i] && ((i - p + N) % N) < bd) begin
        bd   = (i - p + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_hold = 0; m_ptr = 0; m_id = 0; m_tmo = 0;
    end else if (m_owner < 0) begin
      m_tmo = 0;
      if (req != '0) begin
        m_owner = pick(req, m_ptr);
        m_id    = m_owner;
        m_hold  = 1;
      end
    end else begin
      m_tmo = 0;
      if (!req[m_owner] || m_hold == MAX_HOLD) begin
        m_tmo   = req[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_hold++;
      end
    end
  end

  // Per-cycle compare plus a monitor that logs grant runs for directed checks.
  int q_id[$];
  int q_start[$];
  int q_len[$];
  int q_to[$];
  int cyc     = 0;
  int run     = 0;
  int tmo_cnt = 0;
  logic [N-1:0] prev_gnt = '0;

  initial forever begin
    logic [N-1:0] e_gnt;
    @(negedge clk);
    if (chk_en) begin
      e_gnt = '0;
      if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
      chk("gnt", gnt, e_gnt);
      chk("gnt_id", gnt_id, m_id);
      chk("busy", busy, (m_owner >= 0));
      chk("timeout", timeout, m_tmo);
    end
    cyc++;
    if (timeout === 1'b1) tmo_cnt++;
    if (gnt != '0 && prev_gnt == '0) begin
      q_id.push_back(int'(gnt_id));
      q_start.push_back(cyc);
      run = 1;
    end else if (gnt != '0) begin
      run++;
    end
    if (gnt == '0 && prev_gnt != '0) begin
      q_len.push_back(run);
      q_to.push_back(int'(timeout));
    end
    prev_gnt = gnt;
  end

  logic [N-1:0] mask;
  int hold_len[N];
  int held[N];

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    mask = '0;
    for (int i = 0; i < N; i++) held[i] = 0;
    repeat (2) @(negedge clk);
    q_id.delete(); q_start.delete(); q_len.delete(); q_to.delete();
    tmo_cnt = 0;
    rst = 1'b0;
  endtask

  // Each client keeps its request up for hold_len granted cycles, then drops it for a cycle.
  task automatic run_clients(input int cycles, input bit rnd);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          held[i]++;
          if (held[i] >= hold_len[i]) req[i] = 1'b0;
        end else begin
          held[i] = 0;
          req[i]  = mask[i] & (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
      end
    end
  endtask

  task automatic set_hold(input int h);
    for (int i = 0; i < N; i++) hold_len[i] = h;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    mask = '0;
    set_hold(1);
    @(negedge clk);
    chk_en = 1;
    do_reset();
    chk("reset_gnt", gnt, 0);
    chk("reset_gnt_id", gnt_id, 0);
    chk("reset_busy", busy, 0);
    chk("reset_timeout", timeout, 0);

    // Single request on requester 2 held for 3 cycles.
    req = 4'b0100;
    @(negedge clk);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_id", gnt_id, 2);
    repeat (2) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    chk("single_len", q_len[0], 3);
    chk("single_no_timeout", tmo_cnt, 0);
    chk("single_id_holds", gnt_id, 2);

    // All requesting continuously: 0,1,2,3,0 with forced releases.
    do_reset();
    set_hold(100);
    mask = 4'b1111;
    run_clients(47, 0);
    chk("all_count", (q_id.size() >= 5), 1);
    for (int k = 0; k < 5; k++) chk($sformatf("all_order%0d", k), q_id[k], k % N);
    chk("all_len", q_len[0], 8);
    chk("all_timeout", q_to[0], 1);
    chk("all_gap", q_start[1] - (q_start[0] + q_len[0]), 1);

    // Rotation fairness with two requesters and 2-cycle holds.
    do_reset();
    set_hold(2);
    mask = 4'b1001;
    run_clients(14, 0);
    chk("fair_count", (q_id.size() >= 4), 1);
    chk("fair_0", q_id[0], 0);
    chk("fair_1", q_id[1], 3);
    chk("fair_2", q_id[2], 0);
    chk("fair_3", q_id[3], 3);
    chk("fair_len", q_len[0], 2);
    chk("fair_gap", q_start[1] - (q_start[0] + q_len[0]), 1);
    for (int k = 1; k < q_id.size(); k++) chk("fair_no_repeat", (q_id[k] != q_id[k-1]), 1);
    chk("fair_no_timeout", tmo_cnt, 0);

    // Release on the very edge the limit is reached is a normal release.
    do_reset();
    set_hold(8);
    mask = 4'b0001;
    run_clients(12, 0);
    chk("edge_len", q_len[0], 8);
    chk("edge_timeout", q_to[0], 0);
    do_reset();
    set_hold(9);
    mask = 4'b0001;
    run_clients(12, 0);
    chk("over_len", q_len[0], 8);
    chk("over_timeout", q_to[0], 1);

    // Reset in the middle of a grant.
    do_reset();
    req = 4'b0010;
    repeat (5) @(negedge clk);
    chk("mid_gnt", gnt, 4'b0010);
    rst = 1'b1;
    req = 4'b0110;
    @(negedge clk);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_id", gnt_id, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_first_gnt", gnt, 4'b0010);
    chk("mid_first_id", gnt_id, 1);

    // Sole requester repeatedly timed out and re-granted.
    do_reset();
    set_hold(100);
    mask = 4'b0010;
    run_clients(30, 0);
    chk("sole_count", (q_id.size() >= 3), 1);
    for (int k = 0; k < 3; k++) chk($sformatf("sole_id%0d", k), q_id[k], 1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("sole_len%0d", k), q_len[k], 8);
      chk($sformatf("sole_to%0d", k), q_to[k], 1);
      chk($sformatf("sole_gap%0d", k), q_start[k+1] - (q_start[k] + q_len[k]), 1);
    end

    // Random traffic with occasional resets; the per-cycle model compare does the work.
    do_reset();
    for (int b = 0; b < 30; b++) begin
      mask = N'($urandom);
      for (int i = 0; i < N; i++) hold_len[i] = $urandom_range(1, 12);
      if ($urandom_range(0, 3) == 0) begin
        rst = 1'b1;
        run_clients(1, 1);
        rst = 1'b0;
      end
      run_clients(50, 1);
    end

    req = '0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
